// File: rtl/wb_port_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals: the pipeline S3
// writeback, the MCU valid/ready channel, the stall controls and the registered write port.
interface wb_port_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      s3_wdata;
    logic [4:0]       s3_wsel;
    logic             s3_wen;
    logic             mc_valid;
    logic [31:0]      mc_wdata;
    logic [4:0]       mc_wsel;
    logic             mc_ready;
    logic             stall_pipe;
    logic [31:0]      rf_wdata;
    logic [4:0]       rf_wsel;
    logic             rf_wen;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output s3_wdata, s3_wsel, s3_wen, mc_valid, mc_wdata, mc_wsel,
        input  mc_ready, stall_pipe, rf_wdata, rf_wsel, rf_wen, stall_count
    );

    modport slave (
        input  s3_wdata, s3_wsel, s3_wen, mc_valid, mc_wdata, mc_wsel,
        output mc_ready, stall_pipe, rf_wdata, rf_wsel, rf_wen, stall_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline writeback
// (priority) and the multi-cycle unit, forcing a one-cycle stall for a starved MCU.
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    wb_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWait, StStall} state_e;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    state_e           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic [31:0]      rf_wdata_q;
    logic [4:0]       rf_wsel_q;
    logic             rf_wen_q;
    logic [CNT_W-1:0] stall_count_q;
    logic             p_req;
    logic             mc_ready;
    logic             stall_pipe;
    logic             grant_mc;

    assign p_req    = bus.s3_wen & (bus.s3_wsel != 5'd0);
    assign grant_mc = bus.mc_valid & mc_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mc_ready   = 1'b0;
        stall_pipe = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    mc_ready = bus.mc_valid & ~p_req;
                    if (bus.mc_valid && p_req) begin
                        wait_cnt_d = 4'd1;
                        state_d    = (MaxWait == 4'd1) ? StStall : StWait;
                    end
                end
                StWait: begin
                    mc_ready = bus.mc_valid & ~p_req;
                    if (!bus.mc_valid || !p_req) begin
                        // Granted, or the request was withdrawn.
                        state_d    = StIdle;
                        wait_cnt_d = 4'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                        if (wait_cnt_q + 4'd1 == MaxWait) state_d = StStall;
                    end
                end
                StStall: begin
                    stall_pipe = 1'b1;
                    mc_ready   = bus.mc_valid;
                    state_d    = StIdle;
                    wait_cnt_d = 4'd0;
                end
                default: begin
                    state_d    = StIdle;
                    wait_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= 4'd0;
            rf_wdata_q    <= 32'd0;
            rf_wsel_q     <= 5'd0;
            rf_wen_q      <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_q == StStall && stall_count_q != '1) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            // S3 is frozen during a stall and re-presents its write next cycle.
            if (grant_mc) begin
                rf_wdata_q <= bus.mc_wdata;
                rf_wsel_q  <= bus.mc_wsel;
                rf_wen_q   <= (bus.mc_wsel != 5'd0);
            end else if (p_req && state_q != StStall) begin
                rf_wdata_q <= bus.s3_wdata;
                rf_wsel_q  <= bus.s3_wsel;
                rf_wen_q   <= 1'b1;
            end else begin
                rf_wen_q <= 1'b0;
            end
        end
    end

    assign bus.mc_ready    = mc_ready;
    assign bus.stall_pipe  = stall_pipe;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.rf_wsel     = rf_wsel_q;
    assign bus.rf_wen      = rf_wen_q;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a MAX_WAIT=4/CNT_W=16 instance for the main
// scenarios and a MAX_WAIT=1/CNT_W=3 instance to reach counter saturation quickly.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    wb_port_arbiter_if #(.CNT_W(16)) bus0 ();
    wb_port_arbiter_if #(.CNT_W(3))  bus1 ();

    wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    wb_port_arbiter #(.MAX_WAIT(1), .CNT_W(3))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic s3_wen, input logic [4:0] s3_wsel,
                          input logic [31:0] s3_wdata, input logic mc_valid,
                          input logic [4:0] mc_wsel, input logic [31:0] mc_wdata);
        bus0.s3_wen   = s3_wen;
        bus0.s3_wsel  = s3_wsel;
        bus0.s3_wdata = s3_wdata;
        bus0.mc_valid = mc_valid;
        bus0.mc_wsel  = mc_wsel;
        bus0.mc_wdata = mc_wdata;
    endtask

    initial begin
        logic [31:0] d;
        logic        exp_rdy;
        drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1111_1111);
        bus1.s3_wen = 1'b0; bus1.s3_wsel = 5'd0; bus1.s3_wdata = 32'd0;
        bus1.mc_valid = 1'b0; bus1.mc_wsel = 5'd0; bus1.mc_wdata = 32'd0;

        // Reset: outputs cleared, no grant even with a pending MCU request.
        tick(); tick();
        chk("rst_mc_ready", 64'(bus0.mc_ready), 64'd0);
        chk("rst_stall", 64'(bus0.stall_pipe), 64'd0);
        chk("rst_rf_wen", 64'(bus0.rf_wen), 64'd0);
        chk("rst_rf_wdata", 64'(bus0.rf_wdata), 64'd0);
        chk("rst_count", 64'(bus0.stall_count), 64'd0);
        rst = 1'b0;

        // 1: idle port grants the MCU at once.
        drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5);
        #1;
        chk("t1_mc_ready", 64'(bus0.mc_ready), 64'd1);
        tick();
        chk("t1_rf_wen", 64'(bus0.rf_wen), 64'd1);
        chk("t1_rf_wsel", 64'(bus0.rf_wsel), 64'd5);
        chk("t1_rf_wdata", 64'(bus0.rf_wdata), 64'hA5A5_A5A5);
        drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t1_idle_wen", 64'(bus0.rf_wen), 64'd0);
        chk("t1_hold_data", 64'(bus0.rf_wdata), 64'hA5A5_A5A5);

        // 2+3: pipeline hogs r3; MCU forced in on cycle 4; frozen S3 value lands once.
        for (int c = 0; c <= 5; c++) begin
            d = (c <= 4) ? 32'h100 + 32'(c) : 32'h104;
            drive0(1'b1, 5'd3, d, c <= 4, 5'd7, 32'hDEAD_0007);
            #1;
            chk($sformatf("t2_ready_c%0d", c), 64'(bus0.mc_ready), 64'(c == 4));
            chk($sformatf("t2_stall_c%0d", c), 64'(bus0.stall_pipe), 64'(c == 4));
            tick();
            chk($sformatf("t2_wen_c%0d", c), 64'(bus0.rf_wen), 64'd1);
            chk($sformatf("t2_wsel_c%0d", c), 64'(bus0.rf_wsel), (c == 4) ? 64'd7 : 64'd3);
            chk($sformatf("t2_wdata_c%0d", c), 64'(bus0.rf_wdata),
                (c == 4) ? 64'hDEAD_0007 : 64'(d));
        end
        chk("t2_count", 64'(bus0.stall_count), 64'd1);
        drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t3_no_dup", 64'(bus0.rf_wen), 64'd0);

        // 4: r0 writes are never issued; MCU is not blocked by an r0 pipeline write.
        drive0(1'b1, 5'd0, 32'h5555_0000, 1'b1, 5'd0, 32'h0000_1234);
        #1;
        chk("t4_mc_ready", 64'(bus0.mc_ready), 64'd1);
        tick();
        chk("t4_wen_mc", 64'(bus0.rf_wen), 64'd0);
        drive0(1'b1, 5'd0, 32'h5555_0000, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t4_wen_p", 64'(bus0.rf_wen), 64'd0);

        // 5: reset in the middle of WAIT aborts the grant; full wait restarts.
        drive0(1'b1, 5'd3, 32'h200, 1'b1, 5'd8, 32'hCAFE_0008);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", 64'(bus0.mc_ready), 64'd0);
        tick();
        chk("t5_rst_wen", 64'(bus0.rf_wen), 64'd0);
        chk("t5_rst_wsel", 64'(bus0.rf_wsel), 64'd0);
        chk("t5_rst_wdata", 64'(bus0.rf_wdata), 64'd0);
        chk("t5_rst_count", 64'(bus0.stall_count), 64'd0);
        rst = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            #1;
            chk($sformatf("t5_ready_c%0d", c), 64'(bus0.mc_ready), 64'(c == 4));
            chk($sformatf("t5_stall_c%0d", c), 64'(bus0.stall_pipe), 64'(c == 4));
            tick();
        end
        chk("t5_mc_write", 64'(bus0.rf_wdata), 64'hCAFE_0008);
        drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // 6: MAX_WAIT=1 stalls every other cycle; 3-bit count saturates at 7.
        bus1.s3_wen = 1'b1; bus1.s3_wsel = 5'd3; bus1.s3_wdata = 32'h300;
        bus1.mc_valid = 1'b1; bus1.mc_wsel = 5'd4; bus1.mc_wdata = 32'h400;
        for (int n = 1; n <= 10; n++) begin
            #1;
            chk($sformatf("t6_refuse_%0d", n), 64'(bus1.mc_ready), 64'd0);
            tick();
            exp_rdy = 1'b1;
            chk($sformatf("t6_stall_%0d", n), 64'(bus1.stall_pipe), 64'(exp_rdy));
            tick();
            chk($sformatf("t6_count_%0d", n), 64'(bus1.stall_count), (n < 7) ? 64'(n) : 64'd7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
